// File: rtl/dct_ctl_pkg.sv
// Shared types and constants for the DCT block scheduler.
package dct_ctl_pkg;

    localparam int BLK_SIZE = 64;
    localparam int XIN_W    = 8;
    localparam int COEF_W   = 12;
    localparam int NREQ     = 2;
    localparam int IDX_W    = $clog2(BLK_SIZE);
    localparam int WCNT_W   = 10;

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        LOAD,
        WAIT,
        DRAIN
    } sched_state_t;

    function automatic logic [NREQ-1:0] tag_onehot(input logic tag);
        return tag ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not served last wins.
module rr_arb2
    import dct_ctl_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o
);

    // ptr_q set means requester 1 is preferred on the next tie
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && (grant_o != 2'b00)) begin
            ptr_d = grant_o[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dct_block_sched.sv
// Shares one 2-D DCT core between two block requesters: reset core, load 64
// samples, wait for rdy_out, forward 64 tagged coefficients.
module dct_block_sched
    import dct_ctl_pkg::*;
#(
    parameter int CRST_CYC    = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req,
    input  logic [XIN_W-1:0]  req_xin0,
    input  logic [XIN_W-1:0]  req_xin1,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   gnt,
    output logic              core_rst,
    output logic [XIN_W-1:0]  core_xin,
    input  logic              core_rdy,
    input  logic [COEF_W-1:0] core_dct,
    output logic              out_valid,
    output logic [COEF_W-1:0] out_coef,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_tag,
    output logic              out_last,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_underrun
);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BLK_SIZE - 1);
    localparam logic [WCNT_W-1:0] CRST_LAST = WCNT_W'(CRST_CYC - 1);
    localparam logic [WCNT_W-1:0] TMO_LAST  = WCNT_W'(TIMEOUT_CYC - 1);

    sched_state_t      state_q, state_d;
    logic              tag_q, tag_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [NREQ-1:0]   arb_gnt;

    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              core_rst_q, core_rst_d;
    logic [XIN_W-1:0]  core_xin_q, core_xin_d;
    logic              out_valid_q, out_valid_d;
    logic [COEF_W-1:0] out_coef_q, out_coef_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_tag_q, out_tag_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_underrun_q, err_underrun_d;

    rr_arb2 u_arb (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .req_i   (req),
        .en_i    (state_q == IDLE),
        .grant_o (arb_gnt)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            tag_q   <= 1'b0;
            idx_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // wcnt_q times both the core reset and the WAIT timeout
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    tag_d   = arb_gnt[1];
                    wcnt_d  = '0;
                    state_d = CRST;
                end
            end
            CRST: begin
                if (wcnt_q == CRST_LAST) begin
                    wcnt_d  = '0;
                    state_d = LOAD;
                end else begin
                    wcnt_d = wcnt_q + 10'd1;
                end
            end
            LOAD: begin
                idx_d = idx_q + 6'd1;
                if (idx_q == IDX_LAST) begin
                    wcnt_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (core_rdy) begin
                    idx_d   = idx_q + 6'd1;
                    state_d = DRAIN;
                end else if (wcnt_q == TMO_LAST) begin
                    wcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 10'd1;
                end
            end
            DRAIN: begin
                idx_d = idx_q + 6'd1;
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs follow the state being entered, so gnt covers exactly the LOAD cycles
    always_comb begin
        gnt_d          = '0;
        core_rst_d     = (state_d == CRST);
        core_xin_d     = core_xin_q;
        out_valid_d    = 1'b0;
        out_coef_d     = out_coef_q;
        out_idx_d      = out_idx_q;
        out_tag_d      = out_tag_q;
        out_last_d     = 1'b0;
        busy_d         = (state_d != IDLE);
        err_timeout_d  = 1'b0;
        err_underrun_d = 1'b0;
        if (state_d == LOAD) begin
            gnt_d = tag_onehot(tag_d);
        end
        if (state_q == LOAD) begin
            if (req_valid[tag_q]) begin
                core_xin_d = tag_q ? req_xin1 : req_xin0;
            end else begin
                err_underrun_d = 1'b1;
            end
        end
        if ((state_q == WAIT && core_rdy) || state_q == DRAIN) begin
            out_valid_d = 1'b1;
            out_coef_d  = core_dct;
            out_idx_d   = idx_q;
            out_tag_d   = tag_q;
            out_last_d  = (state_q == DRAIN) && (idx_q == IDX_LAST);
        end
        if (state_q == WAIT && !core_rdy && wcnt_q == TMO_LAST) begin
            err_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            gnt_q          <= '0;
            core_rst_q     <= 1'b1;
            core_xin_q     <= '0;
            out_valid_q    <= 1'b0;
            out_coef_q     <= '0;
            out_idx_q      <= '0;
            out_tag_q      <= 1'b0;
            out_last_q     <= 1'b0;
            busy_q         <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_underrun_q <= 1'b0;
        end else begin
            gnt_q          <= gnt_d;
            core_rst_q     <= core_rst_d;
            core_xin_q     <= core_xin_d;
            out_valid_q    <= out_valid_d;
            out_coef_q     <= out_coef_d;
            out_idx_q      <= out_idx_d;
            out_tag_q      <= out_tag_d;
            out_last_q     <= out_last_d;
            busy_q         <= busy_d;
            err_timeout_q  <= err_timeout_d;
            err_underrun_q <= err_underrun_d;
        end
    end

    assign gnt          = gnt_q;
    assign core_rst     = core_rst_q;
    assign core_xin     = core_xin_q;
    assign out_valid    = out_valid_q;
    assign out_coef     = out_coef_q;
    assign out_idx      = out_idx_q;
    assign out_tag      = out_tag_q;
    assign out_last     = out_last_q;
    assign busy         = busy_q;
    assign err_timeout  = err_timeout_q;
    assign err_underrun = err_underrun_q;

endmodule

// File: tb/tb_dct_block_sched.sv
// Bench for dct_block_sched with a behavioural DCT core stand-in and a block-level scoreboard.
module tb_dct_block_sched;

    localparam int CRST_CYC    = 2;
    localparam int TIMEOUT_CYC = 256;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  req;
    logic [7:0]  req_xin0, req_xin1;
    logic [1:0]  req_valid;
    logic [1:0]  gnt;
    logic        core_rst;
    logic [7:0]  core_xin;
    logic        core_rdy;
    logic [11:0] core_dct;
    logic        out_valid;
    logic [11:0] out_coef;
    logic [5:0]  out_idx;
    logic        out_tag, out_last, busy, err_timeout, err_underrun;

    dct_block_sched #(.CRST_CYC(CRST_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_xin0(req_xin0), .req_xin1(req_xin1),
        .req_valid(req_valid), .gnt(gnt), .core_rst(core_rst), .core_xin(core_xin),
        .core_rdy(core_rdy), .core_dct(core_dct), .out_valid(out_valid), .out_coef(out_coef),
        .out_idx(out_idx), .out_tag(out_tag), .out_last(out_last), .busy(busy),
        .err_timeout(err_timeout), .err_underrun(err_underrun)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Requests: a requester asks while it has more issued blocks than served ones
    int issued[2] = '{0, 0};
    int done[2]   = '{0, 0};
    assign req[0] = (issued[0] != done[0]);
    assign req[1] = (issued[1] != done[1]);

    // Core stand-in: samples the 64 cycles after the first post-reset cycle,
    // raises rdy_out 80 cycles after its first sample, dct_2d = sum + beat
    bit no_rdy = 1'b0;
    bit rdy_toggle = 1'b0;
    int c_cnt = 0;
    int c_sum = 0;
    always @(posedge CLK) begin
        if (core_rst) begin
            c_cnt <= 0;
            c_sum <= 0;
        end else begin
            c_cnt <= c_cnt + 1;
            if (c_cnt >= 1 && c_cnt <= 64) c_sum <= c_sum + int'(core_xin);
        end
    end
    always_comb begin
        core_rdy = 1'b0;
        if (!no_rdy && !core_rst && c_cnt >= 81)
            core_rdy = rdy_toggle ? (c_cnt == 81 || c_cnt[0]) : 1'b1;
        core_dct = 12'(c_sum + (c_cnt - 81));
    end

    typedef struct {
        logic [11:0] coef;
        logic [5:0]  idx;
        logic        tag;
    } exp_t;
    exp_t sb[$];

    logic [7:0] base[2] = '{8'h00, 8'h80};
    bit   drop[2] = '{1'b0, 1'b0};
    logic rst_seen;
    always @(posedge CLK) rst_seen <= RST;

    // Requesters plus expected core_xin / coefficient model
    initial begin
        logic [7:0] v;
        bit ok;
        int kk[2];
        logic [7:0] exp_xin;
        int exp_sum;
        logic [1:0] gnt_prev;
        req_xin0 = '0; req_xin1 = '0; req_valid = '0;
        exp_xin = '0; exp_sum = 0; gnt_prev = '0; kk = '{0, 0};
        forever begin
            @(negedge CLK);
            if (rst_seen === 1'b0) exp_xin = 8'h00;
            check("core_xin", core_xin, exp_xin);
            req_valid = 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (gnt[i] && !gnt_prev[i]) begin
                    kk[i] = 0;
                    exp_sum = 0;
                end
                if (gnt[i]) begin
                    v  = base[i] + 8'(kk[i]);
                    ok = !(drop[i] && (kk[i] == 10 || kk[i] == 11));
                    if (i == 0) req_xin0 = ok ? v : ~v;
                    else        req_xin1 = ok ? v : ~v;
                    req_valid[i] = ok;
                    if (ok) exp_xin = v;
                    exp_sum += int'(exp_xin);
                    kk[i]++;
                end
                if (!gnt[i] && gnt_prev[i]) begin
                    done[i]++;
                    if (!no_rdy)
                        for (int n = 0; n < 64; n++)
                            sb.push_back('{coef: 12'(exp_sum + n), idx: 6'(n), tag: i[0]});
                end
            end
            gnt_prev = gnt;
        end
    end

    // Per-cycle compare and event log
    int cyc = 0, nvalid = 0, gnt_cnt = 0, crst_cnt = 0, und_cnt = 0, tmo_cnt = 0, tmo_cyc = 0;
    int gnt_rise[$], first_vcyc[$], last_cyc[$];
    logic [1:0]  gnt_rise_val[$];
    logic [11:0] first_coef[$], last_coef[$];
    logic        tags[$];
    logic        tmo_busy, tmo_busy_prev;
    logic [7:0]  xin11, xin12;
    initial begin
        exp_t e;
        logic [1:0] gnt_mon_prev;
        logic busy_prev;
        gnt_mon_prev = '0; busy_prev = 1'b0;
        forever begin
            @(negedge CLK);
            cyc++;
            check("gnt_onehot", ($countones(gnt) <= 1), 1);
            if (sb.size() == 0) begin
                check("out_valid_unexpected", out_valid, 0);
            end else if (out_valid === 1'b1) begin
                e = sb.pop_front();
                check("out_coef", out_coef, e.coef);
                check("out_idx", out_idx, e.idx);
                check("out_tag", out_tag, e.tag);
                check("out_last", out_last, (e.idx == 6'd63));
            end
            if (out_valid === 1'b1) begin
                nvalid++;
                if (out_idx == 6'd0) begin first_coef.push_back(out_coef); first_vcyc.push_back(cyc); end
                if (out_last) begin last_cyc.push_back(cyc); tags.push_back(out_tag); last_coef.push_back(out_coef); end
            end else begin
                check("out_last_without_valid", out_last, 0);
            end
            if (gnt != 2'b00 && gnt_mon_prev == 2'b00) begin gnt_rise.push_back(cyc); gnt_rise_val.push_back(gnt); end
            if (gnt != 2'b00) gnt_cnt++;
            if (core_rst && busy) crst_cnt++;
            if (err_underrun) und_cnt++;
            if (err_timeout) begin tmo_cnt++; tmo_cyc = cyc; tmo_busy = busy; tmo_busy_prev = busy_prev; end
            if (gnt_rise.size() > 0 && cyc == gnt_rise[$] + 11) xin11 = core_xin;
            if (gnt_rise.size() > 0 && cyc == gnt_rise[$] + 12) xin12 = core_xin;
            gnt_mon_prev = gnt;
            busy_prev = busy;
        end
    end

    task automatic wait_lasts(input int target, input int budget);
        int n = 0;
        while (last_cyc.size() < target && n < budget) begin @(negedge CLK); n++; end
        check("out_last_seen_in_budget", last_cyc.size() >= target, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge CLK);
        while (busy && n < budget) begin @(negedge CLK); n++; end
        check("idle_in_budget", busy, 0);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        int g0, l0, v0, gc0, cr0, u0, t0, n;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_gnt", gnt, 0);
        check("rst_core_rst", core_rst, 1);
        check("rst_core_xin", core_xin, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_coef", out_coef, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_underrun", err_underrun, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("idle_core_rst", core_rst, 0);

        // Single block from requester 0, samples 0x00..0x3F
        g0 = gnt_rise.size(); l0 = last_cyc.size(); v0 = nvalid; gc0 = gnt_cnt;
        cr0 = crst_cnt; u0 = und_cnt; t0 = tmo_cnt;
        base[0] = 8'h00;
        issued[0]++;
        wait_lasts(l0 + 1, 400);
        wait_idle(20);
        check("s1_gnt_cycles", gnt_cnt - gc0, 64);
        check("s1_gnt_value", gnt_rise_val[g0], 1);
        check("s1_core_rst_cycles", crst_cnt - cr0, CRST_CYC);
        check("s1_out_count", nvalid - v0, 64);
        check("s1_out_tag", tags[l0], 0);
        check("s1_first_coef", first_coef[l0], 2016);
        check("s1_last_coef", last_coef[l0], 2079);
        check("s1_latency_gnt_to_out", first_vcyc[l0] - gnt_rise[g0], 82);
        check("s1_underrun", und_cnt - u0, 0);
        check("s1_timeout", tmo_cnt - t0, 0);

        // Both request together straight after reset
        do_reset();
        g0 = gnt_rise.size(); l0 = last_cyc.size();
        issued[0]++; issued[1]++;
        wait_lasts(l0 + 2, 800);
        wait_idle(20);
        check("s2_first_tag", tags[l0], 0);
        check("s2_second_tag", tags[l0 + 1], 1);
        check("s2_first_gnt", gnt_rise_val[g0], 1);
        check("s2_second_gnt", gnt_rise_val[g0 + 1], 2);
        check("s2_gap_last_to_gnt", gnt_rise[g0 + 1] - last_cyc[l0], CRST_CYC + 1);

        // Requester 1 underruns at k=10,11 with rdy_out toggling during drain
        g0 = gnt_rise.size(); l0 = last_cyc.size(); v0 = nvalid; u0 = und_cnt;
        drop[1] = 1'b1; rdy_toggle = 1'b1;
        issued[1]++;
        wait_lasts(l0 + 1, 400);
        wait_idle(20);
        drop[1] = 1'b0; rdy_toggle = 1'b0;
        check("s3_underrun_pulses", und_cnt - u0, 2);
        check("s3_xin_hold_k10", xin11, 8'h89);
        check("s3_xin_hold_k11", xin12, 8'h89);
        check("s3_out_count", nvalid - v0, 64);
        check("s3_first_coef", first_coef[l0], 2013);
        check("s3_tag", tags[l0], 1);

        // Core never answers; requester 1 queues behind the aborted block
        g0 = gnt_rise.size(); l0 = last_cyc.size(); v0 = nvalid; t0 = tmo_cnt;
        no_rdy = 1'b1;
        base[0] = 8'h10;
        issued[0]++;
        n = 0;
        while (!busy && n < 10) begin @(negedge CLK); n++; end
        issued[1]++;
        n = 0;
        while (tmo_cnt == t0 && n < 600) begin @(negedge CLK); n++; end
        no_rdy = 1'b0;
        check("s4_timeout_pulses", tmo_cnt - t0, 1);
        check("s4_timeout_cycle", tmo_cyc - gnt_rise[g0], 64 + TIMEOUT_CYC);
        check("s4_busy_at_timeout", tmo_busy, 0);
        check("s4_busy_before_timeout", tmo_busy_prev, 1);
        check("s4_no_out_during_abort", nvalid - v0, 0);
        wait_lasts(l0 + 1, 400);
        wait_idle(20);
        check("s4_pending_gnt", gnt_rise_val[g0 + 1], 2);
        check("s4_pending_gnt_delay", gnt_rise[g0 + 1] - tmo_cyc, CRST_CYC + 1);
        check("s4_pending_out_count", nvalid - v0, 64);
        check("s4_pending_tag", tags[l0], 1);

        // Reset in the middle of draining a requester-0 block
        base[0] = 8'h20;
        issued[0]++;
        n = 0;
        while (!(out_valid && out_idx == 6'd30) && n < 400) begin @(negedge CLK); n++; end
        check("s5_reached_idx30", out_idx, 30);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        sb.delete();
        @(negedge CLK);
        check("s5_rst_out_valid", out_valid, 0);
        check("s5_rst_core_rst", core_rst, 1);
        check("s5_rst_busy", busy, 0);
        check("s5_rst_gnt", gnt, 0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        l0 = last_cyc.size();
        issued[0]++; issued[1]++;
        wait_lasts(l0 + 2, 800);
        wait_idle(20);
        check("s5_after_rst_first_tag", tags[l0], 0);
        check("s5_after_rst_second_tag", tags[l0 + 1], 1);

        repeat (5) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at time %0t, required end earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
